compressor_core: RTL and testbench
==================================

# compressor_core

Single-clock, order-0 context-mixing-free binary arithmetic compressor. It sits between a byte input stream and eight per-bit-lane output byte streams. Each input byte is coded MSB first. Every bit position owns its own arithmetic coder (lane 0..7), and all lanes share one adaptive probability table indexed by the partial-byte context. On the last input byte, all eight lanes are flushed and the final output byte is marked with `out_last`.

## Interface
- `RATE`, default 4: probability adaptation shift.
- `P_INIT`, default 2048: initial 12-bit probability of bit==1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-high; clock `clk`.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: core accepts the byte this cycle.
- `in_byte` in 8: input data.
- `in_last` in 1: final byte of the stream.
- `init_done` out 1: probability table initialised; `in_ready` is never high while this is low.
- `out_valid` out 1: output byte valid.
- `out_ready` in 1: sink accepts.
- `out_idx` out 8: lane number 0..7; bits [7:3] always 0.
- `out_byte` out 8: coded byte.
- `out_last` out 1: final byte of the compressed stream.

## Operation
- **Reset values:** `in_ready`=0, `init_done`=0, `out_valid`=0, `out_idx`=0, `out_byte`=0, `out_last`=0. All lanes start with x1=0x00000000 and x2=0xFFFFFFFF. The FSM enters INIT.
- **Probability table:** 256 entries × 12 bits, RAM-compatible with one read and one write per cycle. Entry 0 is unused.
- **INIT:** a counter writes `P_INIT` to entries 0..255, one per cycle (256 cycles). The FSM then goes to IDLE and `init_done` is set to 1.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`:
  - latch the byte and `in_last`;
  - set ctx=1 and lane k=0;
  - go to CODE.
- **CODE (lane k):**
  - y = byte[7-k]; p = table[ctx].
  - xmid = x1 + ((x2-x1)>>12)*p, using a 20×12 product truncated to 32 bits.
  - If y=1: x2=xmid. If y=0: x1=xmid+1.
  - If y=1: p += (4096-p)>>RATE. Otherwise: p -= p>>RATE. Write p back to table[ctx].
  - ctx = {ctx[6:0], y}.
  - Go to SHIFT.
- **SHIFT (lane k):**
  - While x1[31:24]==x2[31:24]: emit x2[31:24] with idx=k, then x1<<=8 and x2=(x2<<8)|0xFF. One byte is emitted per cycle, and only when the output slot is free.
  - When the top bytes differ:
    - if k<7: k++ and go to CODE;
    - else if the latched last flag is set: go to FLUSH with k=0;
    - else go to IDLE.
- **FLUSH:** for k=0..7, emit x1[31:24] with idx=k, one per free slot. Lane 7's byte carries `out_last`=1. After that byte is loaded, all lanes are reset to x1=0 and x2=0xFFFFFFFF, `init_done` drops to 0, and the FSM goes to INIT. The next stream therefore starts from fresh state.
- **Output slot:** a single register.
  - Free when `out_valid`=0, or when `out_valid`&`out_ready` in the same cycle.
  - Loading sets `out_valid`=1.
  - A handshake without a reload clears `out_valid`.
  - While `out_valid`=1 and `out_ready`=0, `out_byte`/`out_idx`/`out_last` stay stable.

## Timing
- **Init latency:** `init_done` rises 256 cycles after reset deassertion.
- **Per-byte cost:** minimum 16 cycles (8 CODE + 8 SHIFT), plus one cycle per emitted byte, plus stall cycles while the output slot is occupied.
- **Output latency:** an emitted byte appears on `out_valid` the cycle after its SHIFT/FLUSH load.
- **Input acceptance:** `in_ready` is high only in IDLE. Bytes presented at other times wait; nothing is dropped.
- **Reset mid-operation:**
  - immediately clears all outputs, including any pending output byte;
  - restarts INIT;
  - discards partially coded data.
- **Stalls:** a stalled output never stalls CODE timing retroactively. SHIFT/FLUSH simply hold their state.

## Structure
- The shared package holds:
  - the FSM state enum (INIT, IDLE, CODE, SHIFT, FLUSH);
  - the constants PROB_W=12, X_W=32, LANES=8, CTX_ENTRIES=256.
- One sub-module, `arith_coder_lane_bank`: eight x1/x2 register pairs with the xmid/update/shift datapath for the selected lane.
- The probability table is inferred RAM in the top level.

## Test plan
- **Reset/init:** release reset → `init_done`=0 for 256 cycles, then 1. `in_ready`=1 in IDLE.
- **Single byte 0x00 with last:** every lane gives xmid=0x7FFFF800 and x1 becomes 0x7FFFF801. No SHIFT emits. Flush emits 0x7F on idx 0..7 in order, `out_last` only on idx 7.
- **Single byte 0xFF with last:** every lane ends with x2=0x7FFFF800. Flush emits 0x00 on idx 0..7. table[1] reads back 2176.
- **Long stream of identical bytes:** probabilities adapt, and SHIFT emits bytes with the correct idx. A software model of the same algorithm must reproduce every lane's byte sequence exactly.
- **Output backpressure:** hold `out_ready`=0 for 50 cycles mid-stream → `out_valid` and data stay stable. No byte is lost or duplicated, and `in_ready` stays low until SHIFT finishes.
- **Reset mid-stream:** assert `rst_n` during CODE → `out_valid`=0 immediately. INIT reruns, and the following stream matches the fresh-state model output.

Source files
------------

// File: rtl/compressor_core_pkg.sv
// rtl/compressor_core_pkg.sv - shared types, widths and probability update helper for compressor_core
package compressor_core_pkg;

    localparam int PROB_W      = 12;
    localparam int X_W         = 32;
    localparam int LANES       = 8;
    localparam int LANE_W      = 3;
    localparam int CTX_ENTRIES = 256;
    localparam int CTX_W       = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CODE,
        ST_SHIFT,
        ST_FLUSH
    } state_t;

    // Move p toward 4096 on a one, toward 0 on a zero, by 1/2^rate of the gap.
    function automatic logic [PROB_W-1:0] prob_update(input logic [PROB_W-1:0] p,
                                                      input logic y,
                                                      input int rate);
        logic [PROB_W:0] room;
        room = 13'd4096 - {1'b0, p};
        if (y) begin
            return p + PROB_W'(room >> rate);
        end
        return p - (p >> rate);
    endfunction

endpackage

// File: rtl/arith_coder_lane_bank.sv
// rtl/arith_coder_lane_bank.sv - eight x1/x2 interval registers with the range split and byte shift datapath
module arith_coder_lane_bank
    import compressor_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANE_W-1:0] sel,
    input  logic              code_en,
    input  logic              y,
    input  logic [PROB_W-1:0] p,
    input  logic              shift_en,
    input  logic              clear,
    output logic [7:0]        x1_top,
    output logic [7:0]        x2_top,
    output logic              top_match
);

    logic [X_W-1:0] x1_r [LANES];
    logic [X_W-1:0] x2_r [LANES];

    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [X_W-1:0] span;
    logic [X_W-1:0] prod;
    logic [X_W-1:0] xmid;

    assign x1 = x1_r[sel];
    assign x2 = x2_r[sel];

    // 20-bit range times 12-bit probability; the product fits 32 bits exactly.
    assign span = {12'd0, x2[X_W-1:12]} - {12'd0, x1[X_W-1:12]} - {31'd0, (x2[11:0] < x1[11:0])};
    assign prod = span * {20'd0, p};
    assign xmid = x1 + prod;

    assign x1_top    = x1[X_W-1:X_W-8];
    assign x2_top    = x2[X_W-1:X_W-8];
    assign top_match = (x1_top == x2_top);

    // Interval registers: full-range reset, split on code, byte shift-out on shift.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '1;
            end
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '1;
            end
        end else if (code_en) begin
            if (y) begin
                x2_r[sel] <= xmid;
            end else begin
                x1_r[sel] <= xmid + 32'd1;
            end
        end else if (shift_en) begin
            x1_r[sel] <= {x1[X_W-9:0], 8'h00};
            x2_r[sel] <= {x2[X_W-9:0], 8'hFF};
        end
    end

endmodule

// File: rtl/compressor_core.sv
// rtl/compressor_core.sv - per-bit-lane binary arithmetic compressor with shared adaptive probability table
module compressor_core
    import compressor_core_pkg::*;
#(
    parameter int RATE   = 4,
    parameter int P_INIT = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       init_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_idx,
    output logic [7:0] out_byte,
    output logic       out_last
);

    state_t state;
    state_t next_state;

    logic [CTX_W-1:0]  init_cnt;
    logic [LANE_W-1:0] k;
    logic [CTX_W-1:0]  ctx;
    logic [7:0]        byte_q;
    logic              last_q;

    logic [PROB_W-1:0] prob_ram [CTX_ENTRIES];
    logic [PROB_W-1:0] rd_q;
    logic [CTX_W-1:0]  rd_addr;
    logic              ram_we;
    logic [CTX_W-1:0]  ram_waddr;
    logic [PROB_W-1:0] ram_wdata;

    logic              y;
    logic [PROB_W-1:0] p_new;
    logic              slot_free;
    logic              load;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              code_en;
    logic              shift_en;
    logic              lane_clear;
    logic [7:0]        x1_top;
    logic [7:0]        x2_top;
    logic              top_match;

    assign y         = byte_q[3'd7 - k];
    assign p_new     = prob_update(rd_q, y, RATE);
    assign slot_free = !out_valid || out_ready;

    arith_coder_lane_bank u_lanes (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (k),
        .code_en   (code_en),
        .y         (y),
        .p         (rd_q),
        .shift_en  (shift_en),
        .clear     (lane_clear),
        .x1_top    (x1_top),
        .x2_top    (x2_top),
        .top_match (top_match)
    );

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: init sweep, accept, code/shift per lane, optional flush back to init.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  if (init_cnt == 8'hFF) next_state = ST_IDLE;
            ST_IDLE:  if (in_valid) next_state = ST_CODE;
            ST_CODE:  next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (!top_match) begin
                    if (k != 3'd7)   next_state = ST_CODE;
                    else if (last_q) next_state = ST_FLUSH;
                    else             next_state = ST_IDLE;
                end
            end
            ST_FLUSH: if (slot_free && k == 3'd7) next_state = ST_INIT;
            default:  next_state = ST_INIT;
        endcase
    end

    // State-decoded controls for the lanes, the table port and the output slot.
    always_comb begin
        in_ready   = 1'b0;
        init_done  = (state != ST_INIT);
        code_en    = 1'b0;
        shift_en   = 1'b0;
        lane_clear = 1'b0;
        load       = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = ctx;
        ram_wdata  = p_new;
        rd_addr    = ctx;
        case (state)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt;
                ram_wdata = PROB_W'(P_INIT);
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                rd_addr  = 8'd1;
            end
            ST_CODE: begin
                code_en = 1'b1;
                ram_we  = 1'b1;
            end
            ST_SHIFT: begin
                if (top_match && slot_free) begin
                    load      = 1'b1;
                    load_byte = x2_top;
                    shift_en  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_byte  = x1_top;
                    load_last  = (k == 3'd7);
                    lane_clear = (k == 3'd7);
                end
            end
            default: ;
        endcase
    end

    // Byte latch, lane index, context and init sweep counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            init_cnt <= '0;
            k        <= '0;
            ctx      <= 8'd1;
            byte_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: init_cnt <= init_cnt + 8'd1;
                ST_IDLE: begin
                    if (in_valid) begin
                        byte_q <= in_byte;
                        last_q <= in_last;
                        ctx    <= 8'd1;
                        k      <= '0;
                    end
                end
                ST_CODE: ctx <= {ctx[6:0], y};
                ST_SHIFT: begin
                    if (!top_match && (k != 3'd7 || last_q)) begin
                        k <= k + 3'd1;
                    end
                end
                ST_FLUSH: if (slot_free) k <= k + 3'd1;
                default: ;
            endcase
        end
    end

    // Single-entry output slot: load wins, a bare handshake empties it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_byte  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_idx   <= {5'd0, k};
            out_byte  <= load_byte;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Probability table: one write and one registered read per cycle. The read
    // address is the context for the next CODE cycle, so the data is ready when
    // CODE starts; the context always grows between codes, so no same-address hazard.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            prob_ram[ram_waddr] <= ram_wdata;
        end
        rd_q <= prob_ram[rd_addr];
    end

endmodule

// File: tb/tb_compressor_core.sv
// tb/tb_compressor_core.sv - table-driven and model-checked bench for compressor_core
module tb_compressor_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_last;
    logic       init_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_idx;
    logic [7:0] out_byte;
    logic       out_last;

    always #5 clk = ~clk;

    compressor_core #(.RATE(4), .P_INIT(2048)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .init_done (init_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [7:0]  b;
        logic [63:0] lanes;
        logic [11:0] tab1;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] data;
        logic       last;
    } out_t;

    out_t got_q[$];
    out_t exp_q[$];
    int   last_cnt = 0;
    int   n_pass   = 0;
    int   n_total  = 0;

    logic [31:0] mx1 [8];
    logic [31:0] mx2 [8];
    int          mtab [256];

    always @(negedge clk) begin
        if (!rst_n && out_valid && out_ready) begin
            got_q.push_back(out_t'{out_idx, out_byte, out_last});
            if (out_last) last_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_last(input int target);
        bit ok;
        ok = 0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            tick();
            if (last_cnt >= target) ok = 1;
        end
        check("stream_end_seen", 32'(ok), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mx1[i] = 32'h0000_0000;
            mx2[i] = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < 256; i++) mtab[i] = 2048;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit last);
        int          ctx;
        int          p;
        bit          y;
        logic [31:0] span;
        logic [63:0] prod;
        logic [31:0] xmid;
        ctx = 1;
        for (int k = 0; k < 8; k++) begin
            y    = b[7-k];
            p    = mtab[ctx];
            span = (mx2[k] - mx1[k]) >> 12;
            prod = 64'(span) * 64'(p);
            xmid = mx1[k] + prod[31:0];
            if (y) mx2[k] = xmid;
            else   mx1[k] = xmid + 32'd1;
            if (y) mtab[ctx] = p + (4096 - p) / 16;
            else   mtab[ctx] = p - p / 16;
            ctx = ((ctx * 2) + int'(y)) % 256;
            while (mx1[k][31:24] == mx2[k][31:24]) begin
                exp_q.push_back(out_t'{8'(k), mx2[k][31:24], 1'b0});
                mx1[k] = mx1[k] << 8;
                mx2[k] = (mx2[k] << 8) | 32'hFF;
            end
        end
        if (last) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(out_t'{8'(k), mx1[k][31:24], (k == 7)});
            model_reset();
        end
    endtask

    task automatic compare_streams(input string name);
        int n;
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_out%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_init_timing(input string name);
        for (int i = 0; i < 255; i++) tick();
        check({name, "_init_done_at_255"}, 32'(init_done), 32'd0);
        tick();
        check({name, "_init_done_at_256"}, 32'(init_done), 32'd1);
        check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t   vecs[5];
        bit     seen;
        int     stable_err;
        out_t   snap;
        logic [7:0] pat [12];

        vecs[0] = '{8'h00, 64'h7F7F7F7F_7F7F7F7F, 12'd1920};
        vecs[1] = '{8'hFF, 64'h00000000_00000000, 12'd2176};
        vecs[2] = '{8'hA5, 64'h007F007F_7F007F00, 12'd2176};
        vecs[3] = '{8'h3C, 64'h7F7F0000_00007F7F, 12'd1920};
        vecs[4] = '{8'h01, 64'h7F7F7F7F_7F7F7F00, 12'd1920};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();

        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fields", {15'd0, out_idx, out_byte, out_last}, 32'd0);
        rst_n = 1'b0;
        check_init_timing("boot");

        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            send_byte(vecs[v].b, 1'b1);
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                if (out_valid) seen = 1;
                else tick();
            end
            check($sformatf("vec%0d_first_out", v), 32'(seen), 32'd1);
            check($sformatf("vec%0d_table1", v), 32'(dut.prob_ram[1]), 32'(vecs[v].tab1));
            wait_last(last_cnt + 1);
            check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'd8);
            for (int j = 0; j < 8 && j < got_q.size(); j++) begin
                check($sformatf("vec%0d_lane%0d", v, j), 32'(got_q[j]),
                      32'(out_t'{8'(j), vecs[v].lanes[63-8*j -: 8], (j == 7)}));
            end
        end

        got_q.delete();
        exp_q.delete();
        model_reset();
        for (int i = 0; i < 48; i++) model_byte(8'hA5, (i == 47));
        stable_err = 0;
        seen = 0;
        fork
            begin
                for (int i = 0; i < 48; i++) send_byte(8'hA5, (i == 47));
            end
            begin
                for (int c = 0; c < 100; c++) tick();
                for (int c = 0; c < 2000 && !seen; c++) begin
                    tick();
                    if (out_valid) seen = 1;
                end
                out_ready = 1'b0;
                snap = out_t'{out_idx, out_byte, out_last};
                for (int c = 0; c < 50; c++) begin
                    tick();
                    if (!out_valid || out_t'{out_idx, out_byte, out_last} !== snap) stable_err++;
                end
                out_ready = 1'b1;
            end
        join
        check("bp_hold_started", 32'(seen), 32'd1);
        check("bp_stable_cycles_bad", 32'(stable_err), 32'd0);
        wait_last(last_cnt + 1);
        compare_streams("long");

        out_ready = 1'b0;
        send_byte(8'h00, 1'b1);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (out_valid) seen = 1;
            else tick();
        end
        for (int c = 0; c < 5; c++) tick();
        check("pend_held_valid", 32'(out_valid), 32'd1);
        check("pend_held_data", {16'd0, out_idx, out_byte}, 32'h0000_007F);
        rst_n = 1'b1;
        #1;
        check("pend_rst_out_valid", 32'(out_valid), 32'd0);
        check("pend_rst_out_byte", 32'(out_byte), 32'd0);
        check("pend_rst_init_done", 32'(init_done), 32'd0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        check_init_timing("pend");

        got_q.delete();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        tick();
        rst_n = 1'b0;
        check_init_timing("mid");

        got_q.delete();
        exp_q.delete();
        model_reset();
        for (int i = 0; i < 12; i++) pat[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 12; i++) model_byte(pat[i], (i == 11));
        for (int i = 0; i < 12; i++) send_byte(pat[i], (i == 11));
        wait_last(last_cnt + 1);
        compare_streams("fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
